screen_image_stream: RTL and testbench

Parametrised full-screen image painter for the game-console screen set (title, win, lose, pause). It streams a selectable image from an external image ROM into the display framebuffer, either once or continuously. It also generates an armed, maskable "any key" exit pulse with a minimum display time. Each screen module instantiates it instead of carrying its own ROM streaming and key-edge logic.

---
 rtl/screen_image_stream.sv | 178 +++++++++++++++++
 tb/tb_screen_image_stream.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/screen_image_stream.sv
// Full-screen image painter: streams ROM image into framebuffer, plus armed any-key exit pulse.
// Write latency ROM_LAT+1 from address issue, 1 pixel/cycle; no backpressure, enable low flushes.
`ifndef DISP_ADDR_WIDTH
`define DISP_ADDR_WIDTH 17
`endif

module screen_image_stream #(
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int NUM_IMG    = 2,
    parameter int ROM_AW     = 18,
    parameter int FB_AW      = `DISP_ADDR_WIDTH,
    parameter int PIX_W      = 12,
    parameter int ROM_LAT    = 1,
    parameter int KEY_W      = 26,
    parameter int HOLD_CYC   = 0,
    parameter int CONTINUOUS = 1,
    localparam int SEL_W     = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [SEL_W-1:0]  img_sel,
    input  logic [KEY_W-1:0]  key_status,
    input  logic [KEY_W-1:0]  key_mask,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [31:0]       fb_wdata,
    output logic              frame_done,
    output logic              screen_done
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int PIPE_W = ROM_LAT * FB_AW;
    localparam int HOLD_W = (HOLD_CYC > 0) ? $clog2(HOLD_CYC + 1) : 1;
    localparam logic [FB_AW-1:0]  LAST_PIX = FB_AW'(NPIX - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);

    typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

    state_t                          state_q, state_d;
    logic [FB_AW-1:0]                pix_q, pix_d;
    logic [ROM_AW-1:0]               base_q, base_d;
    logic [ROM_AW-1:0]               sel_base;
    logic                            issue;
    logic [ROM_LAT-1:0]              vld_q, vld_d;
    logic [ROM_LAT-1:0][FB_AW-1:0]   adr_q, adr_d;
    logic                            fb_we_q, fb_we_d;
    logic [FB_AW-1:0]                fb_addr_q, fb_addr_d;
    logic [PIX_W-1:0]                fb_wdata_q, fb_wdata_d;
    logic                            frame_done_q, frame_done_d;
    logic [HOLD_W-1:0]               hold_q, hold_d;
    logic                            armed_q, armed_d;
    logic [KEY_W-1:0]                key_prev_q, key_prev_d;
    logic                            screen_done_q, screen_done_d;
    logic                            fire;

    // Out-of-range selections fall back to image 0.
    always_comb begin
        sel_base = '0;
        if (32'(img_sel) < NUM_IMG) begin
            sel_base = ROM_AW'(img_sel) * ROM_AW'(NPIX);
        end
    end

    always_comb begin
        state_d = state_q;
        pix_d   = pix_q;
        base_d  = base_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                pix_d = '0;
                if (enable) begin
                    base_d  = sel_base;
                    state_d = PAINT;
                end
            end
            PAINT: begin
                issue = 1'b1;
                if (pix_q == LAST_PIX) begin
                    pix_d = '0;
                    if (CONTINUOUS != 0) begin
                        base_d = sel_base;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    pix_d = pix_q + FB_AW'(1);
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            pix_d   = '0;
            issue   = 1'b0;
        end
    end

    assign rom_addr = (state_q == PAINT) ? (base_q + ROM_AW'(pix_q)) : '0;

    // Valid/address shift register tracks each ROM read until its data returns.
    always_comb begin
        vld_d        = ROM_LAT'({vld_q, issue});
        adr_d        = PIPE_W'({adr_q, pix_q});
        fb_we_d      = vld_q[ROM_LAT-1];
        fb_addr_d    = adr_q[ROM_LAT-1];
        fb_wdata_d   = rom_data;
        frame_done_d = vld_q[ROM_LAT-1] && (adr_q[ROM_LAT-1] == LAST_PIX);
        if (!enable) begin
            vld_d        = '0;
            fb_we_d      = 1'b0;
            frame_done_d = 1'b0;
        end
    end

    always_comb begin
        key_prev_d = key_status;
        fire       = armed_q && enable && (|(key_status & ~key_prev_q & key_mask));
        screen_done_d = fire;
        hold_d     = hold_q;
        armed_d    = armed_q;
        if (!enable) begin
            hold_d = '0;
        end else if (hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
        end
        // Arming needs all masked keys up, so a key held across enable never exits.
        if (!enable || fire) begin
            armed_d = 1'b0;
        end else if ((hold_q == HOLD_MAX) && ((key_status & key_mask) == '0)) begin
            armed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pix_q         <= '0;
            base_q        <= '0;
            vld_q         <= '0;
            adr_q         <= '0;
            fb_we_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_wdata_q    <= '0;
            frame_done_q  <= 1'b0;
            hold_q        <= '0;
            armed_q       <= 1'b0;
            key_prev_q    <= '0;
            screen_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pix_q         <= pix_d;
            base_q        <= base_d;
            vld_q         <= vld_d;
            adr_q         <= adr_d;
            fb_we_q       <= fb_we_d;
            fb_addr_q     <= fb_addr_d;
            fb_wdata_q    <= fb_wdata_d;
            frame_done_q  <= frame_done_d;
            hold_q        <= hold_d;
            armed_q       <= armed_d;
            key_prev_q    <= key_prev_d;
            screen_done_q <= screen_done_d;
        end
    end

    assign fb_we       = fb_we_q;
    assign fb_addr     = fb_addr_q;
    assign fb_wdata    = 32'(fb_wdata_q);
    assign frame_done  = frame_done_q;
    assign screen_done = screen_done_q;

endmodule

// File: tb/tb_screen_image_stream.sv
// Directed bench: 4x2 images, continuous instance A (HOLD_CYC=10) and one-shot instance B.
module tb_screen_image_stream;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        enable_a = 1'b0, enable_b = 1'b0;
    logic [0:0]  img_sel_a = 1'b0, img_sel_b = 1'b0;
    logic [25:0] key_status = '0, key_mask = '0;
    logic [17:0] rom_addr_a, rom_addr_b;
    logic [11:0] rom_data_a = '0, rom_data_b = '0;
    logic        fb_we_a, fb_we_b, frame_done_a, frame_done_b, screen_done_a, screen_done_b;
    logic [16:0] fb_addr_a, fb_addr_b;
    logic [31:0] fb_wdata_a, fb_wdata_b;

    int errors = 0;
    int checks = 0;

    screen_image_stream #(
        .IMG_W(4), .IMG_H(2), .NUM_IMG(2), .ROM_AW(18), .FB_AW(17), .PIX_W(12),
        .ROM_LAT(1), .KEY_W(26), .HOLD_CYC(10), .CONTINUOUS(1)
    ) u_cont (
        .clk(clk), .reset_n(reset_n), .enable(enable_a), .img_sel(img_sel_a),
        .key_status(key_status), .key_mask(key_mask), .rom_addr(rom_addr_a),
        .rom_data(rom_data_a), .fb_we(fb_we_a), .fb_addr(fb_addr_a),
        .fb_wdata(fb_wdata_a), .frame_done(frame_done_a), .screen_done(screen_done_a)
    );

    screen_image_stream #(
        .IMG_W(4), .IMG_H(2), .NUM_IMG(2), .ROM_AW(18), .FB_AW(17), .PIX_W(12),
        .ROM_LAT(1), .KEY_W(26), .HOLD_CYC(0), .CONTINUOUS(0)
    ) u_once (
        .clk(clk), .reset_n(reset_n), .enable(enable_b), .img_sel(img_sel_b),
        .key_status(key_status), .key_mask(key_mask), .rom_addr(rom_addr_b),
        .rom_data(rom_data_b), .fb_we(fb_we_b), .fb_addr(fb_addr_b),
        .fb_wdata(fb_wdata_b), .frame_done(frame_done_b), .screen_done(screen_done_b)
    );

    function automatic logic [11:0] rom_f(input logic [17:0] a);
        return {4'hA, a[7:0]};
    endfunction

    // One-cycle-latency ROM models.
    always @(posedge clk) begin
        rom_data_a <= rom_f(rom_addr_a);
        rom_data_b <= rom_f(rom_addr_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        sel;
        logic [17:0] rom;
        logic        we;
        logic [16:0] fa;
        logic [31:0] fd;
        logic        fdone;
    } pvec_t;

    typedef struct {
        logic        en;
        logic [25:0] key;
        logic [25:0] mask;
        logic        done;
    } kvec_t;

    pvec_t ptab[20];
    kvec_t ktab[34];
    int    kn = 0;

    task automatic kadd(input logic en, input logic [25:0] key, input logic [25:0] mask,
                        input logic done);
        ktab[kn].en   = en;
        ktab[kn].key  = key;
        ktab[kn].mask = mask;
        ktab[kn].done = done;
        kn++;
    endtask

    initial begin
        int nw, nfd, last;
        logic [25:0] b0, b1, b2, b3, all;
        b0 = 26'h1; b1 = 26'h2; b2 = 26'h4; b3 = 26'h8; all = '1;

        // Paint table: img_sel 1 -> 0 mid first frame, back to 1 in the second frame.
        for (int c = 0; c < 20; c++) begin
            ptab[c].sel = (c < 4 || c >= 12);
            ptab[c].rom = 18'(((c / 8) == 1 ? 0 : 8) + (c % 8));
            ptab[c].we  = (c >= 2);
            ptab[c].fa  = '0;
            ptab[c].fd  = '0;
            ptab[c].fdone = 1'b0;
            if (c >= 2) begin
                ptab[c].fa    = 17'((c - 2) % 8);
                ptab[c].fd    = 32'(rom_f(ptab[c-2].rom));
                ptab[c].fdone = (((c - 2) % 8) == 7);
            end
        end

        // Exit table: key 3 held at enable rise, released, early press, armed press at 15.
        for (int c = 0; c < 19; c++) begin
            kadd(1'b1, (c < 5 || (c >= 8 && c < 11) || c >= 15) ? b3 : '0, all, c == 15);
        end
        kadd(1, '0, b0, 0);      kadd(1, '0, b0, 0);
        kadd(1, b2, b0, 0);      kadd(1, b2, b0, 0);
        kadd(1, '0, b0, 0);      kadd(1, b0 | b1, b0, 1);
        kadd(1, b0 | b1, b0, 0); kadd(1, b0, b0, 0);
        kadd(1, b0 | b1, b0, 0); kadd(1, '0, b0, 0);
        kadd(1, b0, b0, 1);      kadd(1, b0, b0, 0);
        kadd(1, '0, b0, 0);      kadd(0, b0, b0, 0);
        kadd(0, '0, b0, 0);

        // Reset state
        #2;
        chk("rst_rom_addr", 32'(rom_addr_a), 0);
        chk("rst_fb_we", 32'(fb_we_a), 0);
        chk("rst_fb_addr", 32'(fb_addr_a), 0);
        chk("rst_fb_wdata", fb_wdata_a, 0);
        chk("rst_frame_done", 32'(frame_done_a), 0);
        chk("rst_screen_done", 32'(screen_done_a), 0);
        chk("rst_b_outs", 32'({rom_addr_b, fb_we_b, fb_addr_b, frame_done_b, screen_done_b}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Continuous painting with mid-frame image change
        img_sel_a = 1'b1;
        enable_a  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 img_sel_a = ptab[c].sel;
            @(negedge clk);
            chk($sformatf("paint_rom_addr[%0d]", c), 32'(rom_addr_a), 32'(ptab[c].rom));
            chk($sformatf("paint_we[%0d]", c), 32'(fb_we_a), 32'(ptab[c].we));
            chk($sformatf("paint_fdone[%0d]", c), 32'(frame_done_a), 32'(ptab[c].fdone));
            if (ptab[c].we) begin
                chk($sformatf("paint_fb_addr[%0d]", c), 32'(fb_addr_a), 32'(ptab[c].fa));
                chk($sformatf("paint_wdata[%0d]", c), fb_wdata_a, ptab[c].fd);
            end
        end

        // Enable drop mid-frame flushes the pipeline
        enable_a = 1'b0;
        @(posedge clk);
        #1;
        chk("drop_fb_we", 32'(fb_we_a), 0);
        chk("drop_rom_addr", 32'(rom_addr_a), 0);
        @(negedge clk);

        // Exit logic table
        key_status = b3;
        key_mask   = all;
        @(negedge clk);
        @(negedge clk);
        for (int r = 0; r < kn; r++) begin
            enable_a   = ktab[r].en;
            key_status = ktab[r].key;
            key_mask   = ktab[r].mask;
            @(posedge clk);
            #1 chk($sformatf("exit_done[%0d]", r), 32'(screen_done_a), 32'(ktab[r].done));
            @(negedge clk);
        end

        // One-shot instance: one frame, then silence until enable toggles
        key_status = '0;
        img_sel_b  = 1'b1;
        enable_b   = 1'b1;
        nw = 0; nfd = 0; last = -1;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (fb_we_b) begin
                chk("once_fb_addr", 32'(fb_addr_b), 32'(nw));
                chk("once_wdata", fb_wdata_b, 32'(rom_f(18'(8 + nw))));
                chk("once_fdone", 32'(frame_done_b), 32'(nw == 7));
                nw++;
                last = c;
            end
            if (frame_done_b) nfd++;
        end
        chk("once_writes", 32'(nw), 8);
        chk("once_frame_dones", 32'(nfd), 1);
        chk("once_last_write_cycle", 32'(last), 9);
        chk("once_done_rom_addr", 32'(rom_addr_b), 0);
        @(negedge clk);
        enable_b = 1'b0;
        @(negedge clk);
        enable_b = 1'b1;
        nw = 0; nfd = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (fb_we_b) nw++;
            if (frame_done_b) nfd++;
        end
        chk("repaint_writes", 32'(nw), 8);
        chk("repaint_frame_dones", 32'(nfd), 1);
        @(negedge clk);

        // Async reset mid-paint at pixel 5
        img_sel_a = 1'b1;
        enable_a  = 1'b1;
        key_mask  = all;
        for (int c = 0; c < 6; c++) @(negedge clk);
        chk("pre_rst_rom_addr", 32'(rom_addr_a), 13);
        chk("pre_rst_fb_we", 32'(fb_we_a), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("arst_rom_addr", 32'(rom_addr_a), 0);
        chk("arst_fb_we", 32'(fb_we_a), 0);
        chk("arst_fb_addr", 32'(fb_addr_a), 0);
        chk("arst_fb_wdata", fb_wdata_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("restart_rom_addr0", 32'(rom_addr_a), 8);
        chk("restart_fb_we", 32'(fb_we_a), 0);
        @(negedge clk);
        chk("restart_rom_addr1", 32'(rom_addr_a), 9);
        key_status = b0;
        @(posedge clk);
        #1 chk("restart_unarmed", 32'(screen_done_a), 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
